// File: rtl/video_timing_ctrl_if.sv
// Raster timing bundle between the timing controller and the pixel/TMDS stage.
// Master is the timing controller; slave is the consumer that gates it with en_in.
interface video_timing_ctrl_if;
  logic        en_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hs_out;
  logic        vs_out;
  logic        ad_out;
  logic        nf_out;
  logic [5:0]  fc_out;

  modport master (
    input  en_in,
    output hcount_out, vcount_out, hs_out, vs_out,
    output ad_out, nf_out, fc_out
  );

  modport slave (
    output en_in,
    input  hcount_out, vcount_out, hs_out, vs_out,
    input  ad_out, nf_out, fc_out
  );
endinterface

// File: rtl/video_timing_ctrl.sv
// Raster timing controller: pixel/line counters, syncs, active-draw,
// new-frame strobe and frame counter for the HDMI TMDS encoder stage.
module video_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FPS      = 60,
  parameter bit SYNC_POS = 1'b1
) (
  input logic                clk_in,
  input logic                rst_n_in,
  video_timing_ctrl_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] HS_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]  FC_MAX = 6'(FPS - 1);

  if (H_TOTAL > 2048) begin : g_h_chk
    $error("H_TOTAL exceeds 11-bit hcount");
  end
  if (V_TOTAL > 1024) begin : g_v_chk
    $error("V_TOTAL exceeds 10-bit vcount");
  end
  if (FPS > 64) begin : g_fc_chk
    $error("FPS exceeds 6-bit frame counter");
  end

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [5:0]  fc_q, fc_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ad_q, ad_d;
  logic        nf_q, nf_d;
  logic        hs_on, vs_on;

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    fc_d  = fc_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    ad_d  = ad_q;
    nf_d  = 1'b0;
    hs_on = 1'b0;
    vs_on = 1'b0;
    if (vif.en_in) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
      // Outputs are derived from the next counters so they align with them.
      hs_on = (h_d >= HS_LO) && (h_d < HS_HI);
      vs_on = (v_d >= VS_LO) && (v_d < VS_HI);
      hs_d  = SYNC_POS ? hs_on : ~hs_on;
      vs_d  = SYNC_POS ? vs_on : ~vs_on;
      ad_d  = (h_d < H_ACT) && (v_d < V_ACT);
      nf_d  = (h_d == H_ACT) && (v_d == V_ACT);
      if (nf_d) begin
        fc_d = (fc_q == FC_MAX) ? '0 : fc_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
      hs_q <= ~SYNC_POS;
      vs_q <= ~SYNC_POS;
      ad_q <= 1'b0;
      nf_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ad_q <= ad_d;
      nf_q <= nf_d;
    end
  end

  assign vif.hcount_out = h_q;
  assign vif.vcount_out = v_q;
  assign vif.hs_out     = hs_q;
  assign vif.vs_out     = vs_q;
  assign vif.ad_out     = ad_q;
  assign vif.nf_out     = nf_q;
  assign vif.fc_out     = fc_q;
endmodule
